// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues req/gnt/rvalid transactions,
// stalls the front of the pipeline while busy, flags misaligned/timed-out accesses.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEMvalid,
    input  logic [31:0] MEMaluOut,
    input  logic [31:0] MEMwritedata,
    input  logic        MEMmemWrite,
    input  logic        MEMmemtoReg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] MEMreaddata,
    output logic        memStall,
    output logic        alignErr,
    output logic        busErr,
    output logic [31:0] stallCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    localparam logic [7:0] LP_TLAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_tcnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_align_err;
    logic        r_bus_err;
    logic [31:0] r_stall_cnt;

    logic w_access;
    logic w_misalign;
    logic w_tmo;
    logic w_issue;
    logic w_align;
    logic w_capture;
    logic w_abort;
    logic w_stall;

    assign w_access   = MEMvalid & (MEMmemWrite | MEMmemtoReg);
    assign w_misalign = |MEMaluOut[1:0];
    assign w_tmo      = (r_tcnt == LP_TLAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Completion in the last allowed cycle wins over the timeout abort.
    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_issue   = 1'b0;
        w_align   = 1'b0;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_stall = 1'b1;
                    if (w_misalign) begin
                        w_next  = S_DONE;
                        w_align = 1'b1;
                    end else begin
                        w_next  = S_REQ;
                        w_issue = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (mem_gnt && (r_we || mem_rvalid)) begin
                    w_next    = S_DONE;
                    w_capture = !r_we;
                end else if (w_tmo) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end else if (mem_gnt) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_stall = 1'b1;
                if (mem_rvalid) begin
                    w_next    = S_DONE;
                    w_capture = 1'b1;
                end else if (w_tmo) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= 8'd0;
        end else if (w_issue) begin
            r_tcnt <= 8'd0;
        end else if (r_state == S_REQ || r_state == S_RESP) begin
            r_tcnt <= r_tcnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            r_req <= (w_next == S_REQ);
            if (w_issue) begin
                r_we    <= MEMmemWrite;
                r_addr  <= {MEMaluOut[31:2], 2'b00};
                r_wdata <= MEMwritedata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata     <= 32'd0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_align_err <= w_align;
            r_bus_err   <= w_abort;
            if (w_capture) begin
                r_rdata <= mem_rdata;
            end else if (w_abort) begin
                r_rdata <= 32'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign MEMreaddata = r_rdata;
    assign memStall    = w_stall;
    assign alignErr    = r_align_err;
    assign busErr      = r_bus_err;
    assign stallCount  = r_stall_cnt;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a per-access latency/outcome
// model with its own reference memory.
module tb_mem_access_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MEMvalid = 1'b0;
    logic [31:0] MEMaluOut = '0;
    logic [31:0] MEMwritedata = '0;
    logic        MEMmemWrite = 1'b0;
    logic        MEMmemtoReg = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] MEMreaddata;
    logic        memStall;
    logic        alignErr;
    logic        busErr;
    logic [31:0] stallCount;

    int total = 0;
    int bad = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] dmem [64];
    logic [31:0] exp_rd = '0;
    int          exp_stalls = 0;

    mem_access_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .MEMvalid(MEMvalid),
        .MEMaluOut(MEMaluOut), .MEMwritedata(MEMwritedata),
        .MEMmemWrite(MEMmemWrite), .MEMmemtoReg(MEMmemtoReg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .MEMreaddata(MEMreaddata),
        .memStall(memStall), .alignErr(alignErr), .busErr(busErr),
        .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // g: cycles in REQ before gnt; r: cycles after gnt until rvalid (loads).
    task automatic run_instr(input logic wr, input logic rd,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int g, input int r);
        logic is_wr, mis, tmo, done, first;
        int k, stl, reqc, aerr, berr, wcnt, stall_exp, req_exp;
        logic [31:0] rd_done, sc_done;
        is_wr = wr;
        mis = (addr[1:0] != 2'b00);
        k = is_wr ? g : g + r;
        tmo = !mis && (k > T - 1);
        stall_exp = mis ? 1 : (tmo ? T + 1 : k + 2);
        req_exp = mis ? 0 : ((g + 1 < T) ? g + 1 : T);
        stl = 0; reqc = 0; aerr = 0; berr = 0; wcnt = 0;
        done = 1'b0; first = 1'b1;
        rd_done = '0; sc_done = '0;
        MEMvalid = 1'b1;
        MEMmemWrite = wr;
        MEMmemtoReg = rd;
        MEMaluOut = addr;
        MEMwritedata = wd;
        for (int j = 0; j < 64 && !done; j++) begin
            mem_gnt = (j == g + 1);
            if (is_wr) mem_rvalid = 1'($urandom_range(0, 1));
            else mem_rvalid = (j == 0) || (j == g + r + 1);
            mem_rdata = (!is_wr && j == g + r + 1) ? dmem[mem_addr[7:2]]
                                                     : $urandom;
            @(negedge clk);
            if (memStall) stl++;
            if (mem_req) begin
                reqc++;
                if (first) begin
                    first = 1'b0;
                    chk("req_we", 32'(mem_we), 32'(is_wr));
                    chk("req_addr", mem_addr, addr);
                    if (is_wr) chk("req_wdata", mem_wdata, wd);
                end
                if (mem_gnt && mem_we) begin
                    dmem[mem_addr[7:2]] = mem_wdata;
                    wcnt++;
                end
            end
            aerr += int'(alignErr);
            berr += int'(busErr);
            if (!memStall) begin
                done = 1'b1;
                rd_done = MEMreaddata;
                sc_done = stallCount;
            end
            @(posedge clk);
            #1;
        end
        if (is_wr && !mis && !tmo) ref_mem[addr[7:2]] = wd;
        if (!is_wr && !mis && !tmo) exp_rd = ref_mem[addr[7:2]];
        if (tmo) exp_rd = '0;
        exp_stalls += stall_exp;
        chk("finished", 32'(done), 32'd1);
        chk("stall_cycles", 32'(stl), 32'(stall_exp));
        chk("req_cycles", 32'(reqc), 32'(req_exp));
        chk("align_pulses", 32'(aerr), mis ? 32'd1 : 32'd0);
        chk("bus_pulses", 32'(berr), tmo ? 32'd1 : 32'd0);
        chk("writes", 32'(wcnt), (is_wr && !mis && !tmo) ? 32'd1 : 32'd0);
        chk("readdata", rd_done, exp_rd);
        chk("stallCount", sc_done, 32'(exp_stalls));
    endtask

    task automatic idle(input int n);
        MEMvalid = 1'b0;
        mem_gnt = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(negedge clk);
            chk("idle_stall", 32'(memStall), 32'd0);
            chk("idle_req", 32'(mem_req), 32'd0);
            @(posedge clk);
            #1;
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic rand_instr();
        int typ, g, r;
        logic [31:0] a;
        typ = $urandom_range(0, 2);
        a = $urandom;
        if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
        g = ($urandom_range(0, 9) == 0) ? T - 2 + $urandom_range(0, 4)
                                        : $urandom_range(0, 4);
        r = ($urandom_range(0, 9) == 0) ? T - 4 + $urandom_range(0, 6)
                                        : $urandom_range(0, 3);
        run_instr(typ != 1, typ != 0, a, $urandom, g, r);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            dmem[i] = ref_mem[i];
        end
        ref_mem[8] = 32'h1234_5678;
        dmem[8] = 32'h1234_5678;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_rdata", MEMreaddata, 32'd0);
        chk("rst_stall", 32'(memStall), 32'd0);
        chk("rst_count", stallCount, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_instr(1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 0, 0);
        run_instr(1'b0, 1'b1, 32'h0000_0020, 32'h0, 2, 2);
        run_instr(1'b0, 1'b1, 32'h0000_0022, 32'h0, 0, 0);
        run_instr(1'b0, 1'b1, 32'h0000_0040, 32'h0, 0, 40);
        run_instr(1'b1, 1'b0, 32'h0000_0030, 32'hA5A5_0001, 1, 0);
        run_instr(1'b0, 1'b1, 32'h0000_0030, 32'h0, 0, 1);
        run_instr(1'b0, 1'b1, 32'h0000_0034, 32'h0, 0, T - 1);
        run_instr(1'b0, 1'b1, 32'h0000_0038, 32'h0, 0, T);
        run_instr(1'b1, 1'b0, 32'h0000_003C, 32'h5555_AAAA, T - 1, 0);
        run_instr(1'b1, 1'b0, 32'h0000_003C, 32'h7777_0000, T, 0);
        run_instr(1'b1, 1'b1, 32'h0000_0044, 32'hBEEF_0044, 0, 0);

        for (int n = 0; n < 250; n++) rand_instr();

        run_instr(1'b0, 1'b1, 32'h0000_0010, 32'h0, 0, 0);
        MEMaluOut = 32'h0000_0020;
        MEMmemWrite = 1'b0;
        MEMmemtoReg = 1'b1;
        MEMvalid = 1'b1;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        MEMvalid = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_rdata", MEMreaddata, 32'd0);
        chk("mid_rst_stall", 32'(memStall), 32'd0);
        chk("mid_rst_count", stallCount, 32'd0);
        exp_rd = '0;
        exp_stalls = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b1;
            mem_rdata = 32'hBAD0_0BAD;
            @(negedge clk);
            chk("post_rst_stall", 32'(memStall), 32'd0);
            chk("post_rst_req", 32'(mem_req), 32'd0);
        end
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        chk("post_rst_rdata", MEMreaddata, 32'd0);
        for (int n = 0; n < 20; n++) rand_instr();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
